sq_rom_arb: RTL and testbench

Two-port round-robin arbiter that shares one 16-entry squares lookup table (data = addr², addr 0–15) between two requesters. Each requester presents a 4-bit address with a request. The block grants one requester per cycle and returns the registered table value, tagged with the winner's ID. It also keeps per-port saturating grant counters for debug and throughput checks. It sits between the requesting datapath units and the lookup table, and owns the table instance internally.

---
 rtl/sq_rom_arb.sv | 103 ++++++++++
 tb/tb_sq_rom_arb.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sq_rom_arb.sv
// Two-port round-robin arbiter sharing a 16-entry squares table (entry i = i*i).
// Grants, response data/ID and saturating per-port grant counters are all registered.
module sq_rom_arb #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [3:0]       addr0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [3:0]       addr1,
    output logic             gnt1,
    output logic             rvalid,
    output logic [7:0]       rdata,
    output logic             rid,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    // Squares table; the full 4-bit address space is enumerated.
    function automatic logic [7:0] sq_lookup(input logic [3:0] a);
        logic [7:0] v;
        case (a)
            4'd0:    v = 8'd0;
            4'd1:    v = 8'd1;
            4'd2:    v = 8'd4;
            4'd3:    v = 8'd9;
            4'd4:    v = 8'd16;
            4'd5:    v = 8'd25;
            4'd6:    v = 8'd36;
            4'd7:    v = 8'd49;
            4'd8:    v = 8'd64;
            4'd9:    v = 8'd81;
            4'd10:   v = 8'd100;
            4'd11:   v = 8'd121;
            4'd12:   v = 8'd144;
            4'd13:   v = 8'd169;
            4'd14:   v = 8'd196;
            4'd15:   v = 8'd225;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic ptr_r;   // 0: port 0 has priority on contention
    logic elig0_s;
    logic elig1_s;
    logic win0_s;
    logic win1_s;

    // A port's request in its own grant cycle is not eligible, so no back-to-back wins.
    always_comb begin
        elig0_s = req0 & ~gnt0;
        elig1_s = req1 & ~gnt1;
        win0_s  = elig0_s & (~elig1_s | ~ptr_r);
        win1_s  = elig1_s & (~elig0_s |  ptr_r);
    end

    // Arbitration register, response capture and grant counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            rvalid <= 1'b0;
            rdata  <= 8'd0;
            rid    <= 1'b0;
            cnt0   <= '0;
            cnt1   <= '0;
            ptr_r  <= 1'b0;
        end else begin
            gnt0   <= win0_s;
            gnt1   <= win1_s;
            rvalid <= win0_s | win1_s;
            if (win0_s) begin
                rdata <= sq_lookup(addr0);
                rid   <= 1'b0;
                ptr_r <= 1'b1;
            end else if (win1_s) begin
                rdata <= sq_lookup(addr1);
                rid   <= 1'b1;
                ptr_r <= 1'b0;
            end else begin
                rdata <= rdata;
                rid   <= rid;
                ptr_r <= ptr_r;
            end
            if (win0_s && (cnt0 != CNT_MAX)) begin
                cnt0 <= cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt0 <= cnt0;
            end
            if (win1_s && (cnt1 != CNT_MAX)) begin
                cnt1 <= cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt1 <= cnt1;
            end
        end
    end

endmodule

// File: tb/tb_sq_rom_arb.sv
// Directed bench for sq_rom_arb: a per-cycle vector table followed by
// hand-written contention, saturation and reset-in-grant sequences.
module tb_sq_rom_arb;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [3:0] addr0;
    logic       gnt0;
    logic       req1;
    logic [3:0] addr1;
    logic       gnt1;
    logic       rvalid;
    logic [7:0] rdata;
    logic       rid;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int n_chk;
    int n_fail;

    sq_rom_arb #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1),
        .rvalid(rvalid), .rdata(rdata), .rid(rid),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       req0;
        logic [3:0] addr0;
        logic       req1;
        logic [3:0] addr1;
        logic       e_gnt0;
        logic       e_gnt1;
        logic       e_rvalid;
        logic [7:0] e_rdata;
        logic       e_rid;
        logic [7:0] e_cnt0;
        logic [7:0] e_cnt1;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic q0, input int a0,
                                input logic q1, input int a1,
                                input logic g0, input logic g1, input logic rv,
                                input int rd, input logic id, input int c0, input int c1);
        vec_t v;
        v.rst_n = r; v.req0 = q0; v.addr0 = 4'(a0); v.req1 = q1; v.addr1 = 4'(a1);
        v.e_gnt0 = g0; v.e_gnt1 = g1; v.e_rvalid = rv; v.e_rdata = 8'(rd);
        v.e_rid = id; v.e_cnt0 = 8'(c0); v.e_cnt1 = 8'(c1);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic q0, input int a0, input logic q1, input int a1);
        rst_n = r; req0 = q0; addr0 = 4'(a0); req1 = q1; addr1 = 4'(a1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".gnt0"},   int'(gnt0),   int'(v.e_gnt0));
        chk({tag, ".gnt1"},   int'(gnt1),   int'(v.e_gnt1));
        chk({tag, ".rvalid"}, int'(rvalid), int'(v.e_rvalid));
        chk({tag, ".rdata"},  int'(rdata),  int'(v.e_rdata));
        chk({tag, ".rid"},    int'(rid),    int'(v.e_rid));
        chk({tag, ".cnt0"},   int'(cnt0),   int'(v.e_cnt0));
        chk({tag, ".cnt1"},   int'(cnt1),   int'(v.e_cnt1));
    endtask

    vec_t vt[23];

    initial begin
        int grants;
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0; req0 = 1'b0; addr0 = 4'd0; req1 = 1'b0; addr1 = 4'd0;

        // Reset, idle, single request, contention from reset, single port held high.
        vt[0]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
        for (int i = 2; i <= 6; i++) vt[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[7]  = mk(1, 1, 7, 0, 0,   1, 0, 1, 49,  0, 1, 0);
        vt[8]  = mk(1, 0, 7, 0, 0,   0, 0, 0, 49,  0, 1, 0);
        vt[9]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0,   0, 0, 0);
        vt[10] = mk(1, 1, 3, 1, 12,  1, 0, 1, 9,   0, 1, 0);
        vt[11] = mk(1, 0, 3, 1, 12,  0, 1, 1, 144, 1, 1, 1);
        vt[12] = mk(1, 0, 0, 0, 12,  0, 0, 0, 144, 1, 1, 1);
        vt[13] = mk(1, 0, 0, 1, 9,   0, 1, 1, 81,  1, 1, 2);
        vt[14] = mk(1, 0, 0, 1, 9,   0, 0, 0, 81,  1, 1, 2);
        vt[15] = mk(1, 0, 0, 1, 9,   0, 1, 1, 81,  1, 1, 3);
        vt[16] = mk(1, 0, 0, 1, 9,   0, 0, 0, 81,  1, 1, 3);
        vt[17] = mk(1, 0, 0, 1, 9,   0, 1, 1, 81,  1, 1, 4);
        vt[18] = mk(1, 0, 0, 1, 9,   0, 0, 0, 81,  1, 1, 4);
        vt[19] = mk(1, 0, 0, 1, 9,   0, 1, 1, 81,  1, 1, 5);
        vt[20] = mk(1, 0, 0, 1, 9,   0, 0, 0, 81,  1, 1, 5);
        vt[21] = mk(1, 0, 0, 1, 9,   0, 1, 1, 81,  1, 1, 6);
        vt[22] = mk(1, 0, 0, 0, 9,   0, 0, 0, 81,  1, 1, 6);

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].rst_n, vt[i].req0, int'(vt[i].addr0), vt[i].req1, int'(vt[i].addr1));
            chk_all($sformatf("vec%0d", i), vt[i]);
        end

        // Sustained contention from reset: strict 0,1,0,1 alternation.
        drive(0, 0, 0, 0, 0);
        chk_all("cont_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 15, 1, 0);
            chk($sformatf("cont%0d.gnt0", i), int'(gnt0), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("cont%0d.gnt1", i), int'(gnt1), (i % 2 == 1) ? 1 : 0);
            chk($sformatf("cont%0d.rvalid", i), int'(rvalid), 1);
            chk($sformatf("cont%0d.rid", i), int'(rid), i % 2);
            chk($sformatf("cont%0d.rdata", i), int'(rdata), (i % 2 == 0) ? 225 : 0);
        end
        chk("cont_end.cnt0", int'(cnt0), 10);
        chk("cont_end.cnt1", int'(cnt1), 10);

        // Saturation: 300 port-1 grants, counter pinned at 255.
        drive(0, 0, 0, 0, 0);
        chk_all("sat_rst", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        grants = 0;
        for (int i = 0; i < 599; i++) begin
            drive(1, 0, 0, 1, 5);
            if (i % 2 == 0) grants++;
            chk($sformatf("sat%0d.gnt1", i), int'(gnt1), (i % 2 == 0) ? 1 : 0);
            chk($sformatf("sat%0d.cnt1", i), int'(cnt1), (grants > 255) ? 255 : grants);
        end
        chk("sat_end.rdata", int'(rdata), 25);
        chk("sat_end.grants", grants, 300);

        // Reset during a grant cycle with both requests up: no grant, all cleared.
        drive(0, 1, 2, 1, 5);
        chk_all("rst_in_gnt", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(1, 1, 2, 1, 5);
        chk_all("post_rst", mk(1, 0, 0, 0, 0, 1, 0, 1, 4, 0, 1, 0));
        drive(1, 0, 2, 1, 5);
        chk_all("post_rst2", mk(1, 0, 0, 0, 0, 0, 1, 1, 25, 1, 1, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
